// File: rtl/mac_array_fx.sv
// mac_array_fx: A-lane fixed-point multiply-accumulate array.
// Each accepted beat multiplies one scalar by every lane of a matrix row.
// Each lane accumulates its product. On the vector's last beat every lane
// emits a rounded, saturated result, held under valid/ready backpressure.
// Pipeline: P (product) -> ACC (accumulate) -> RND (round/saturate) -> OUT.

module mac_lane_fx #(
   parameter int DW   = 16,
   parameter int FRAC = 8,
   parameter int OW   = 16,
   parameter int AW   = 37
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          acc_en_i,
   input  logic [DW-1:0] vin_i,
   input  logic [DW-1:0] m_i,
   input  logic          p_vld_i,
   input  logic          first_i,
   input  logic          a_done_i,
   output logic [OW-1:0] r_o,
   output logic          sat_o
);
   // Half an output LSB. The expression reduces to 0 when FRAC is 0.
   localparam logic signed [AW-1:0] RND  = AW'((AW'(1) << FRAC) >> 1);
   localparam logic signed [AW-1:0] MAXV = AW'((AW'(1) << (OW-1)) - AW'(1));
   localparam logic signed [AW-1:0] MINV = ~MAXV;

   logic signed [2*DW-1:0] prod_q;
   logic signed [AW-1:0]   acc_q, acc_d, shf;
   logic [OW-1:0]          r_q, r_d;
   logic                   sat_q, sat_d;

   // Next accumulator value; round-half-up and clip the finished sum
   always_comb begin
      acc_d = (first_i ? '0 : acc_q) + {{(AW-2*DW){prod_q[2*DW-1]}}, prod_q};
      shf   = (acc_q + RND) >>> FRAC;
      r_d   = shf[OW-1:0];
      sat_d = 1'b0;
      if (shf > MAXV) begin
         r_d   = MAXV[OW-1:0];
         sat_d = 1'b1;
      end else if (shf < MINV) begin
         r_d   = MINV[OW-1:0];
         sat_d = 1'b1;
      end
   end

   // Product, accumulate and rounded-result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= '0;
         acc_q  <= '0;
         r_q    <= '0;
         sat_q  <= 1'b0;
      end else begin
         if (acc_en_i) prod_q <= $signed(vin_i) * $signed(m_i);
         if (p_vld_i)  acc_q  <= acc_d;
         if (a_done_i) begin
            r_q   <= r_d;
            sat_q <= sat_d;
         end
      end
   end

   assign r_o   = r_q;
   assign sat_o = sat_q;
endmodule

module mac_array_fx #(
   parameter int A       = 2,
   parameter int J       = 14,
   parameter int DW      = 16,
   parameter int FRAC    = 8,
   parameter int OW      = 16,
   // Derived widths; leave at their defaults
   parameter int J_WIDTH = $clog2(J) + 1,
   parameter int AW      = 2*DW + $clog2(J) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DW-1:0]        vinput,
   input  logic                 vinput_tvalid,
   input  logic                 vinput_tlast,
   input  logic [A*DW-1:0]      M_row,
   input  logic                 M_row_tvalid,
   input  logic                 M_row_tlast,
   output logic                 in_tready,
   output logic [A*OW-1:0]      beta,
   output logic                 beta_tvalid,
   input  logic                 beta_tready,
   output logic [A-1:0]         beta_sat,
   output logic [J_WIDTH-1:0]   beta_count,
   output logic                 err_tlast,
   output logic                 err_len
);
   logic                       acc_en, last;
   logic [J_WIDTH-1:0]         cnt_q, cnt_d, p_cnt_q, a_cnt_q, beta_count_q;
   logic                       p_vld_q, p_last_q, first_q, a_done_q, r_done_q;
   logic                       hold_q, beta_tvalid_q, err_tlast_q, err_len_q;
   logic [A-1:0][OW-1:0]       lane_r, beta_q;
   logic [A-1:0]               lane_sat, beta_sat_q;

   assign in_tready = ~hold_q;
   assign acc_en    = vinput_tvalid & M_row_tvalid & in_tready;
   assign last      = vinput_tlast | M_row_tlast | (cnt_q == J_WIDTH'(J-1));

   // Term counter: counts accepted beats, restarts after a closing beat
   always_comb begin
      cnt_d = cnt_q;
      if (acc_en) cnt_d = last ? '0 : cnt_q + J_WIDTH'(1);
   end

   for (genvar a = 0; a < A; a++) begin : g_lane
      mac_lane_fx #(.DW(DW), .FRAC(FRAC), .OW(OW), .AW(AW)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .acc_en_i (acc_en),
         .vin_i    (vinput),
         .m_i      (M_row[a*DW +: DW]),
         .p_vld_i  (p_vld_q),
         .first_i  (first_q),
         .a_done_i (a_done_q),
         .r_o      (lane_r[a]),
         .sat_o    (lane_sat[a])
      );
   end

   // Pipeline control: stage valids, term count carried with the last beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         p_cnt_q  <= '0;
         a_cnt_q  <= '0;
         p_vld_q  <= 1'b0;
         p_last_q <= 1'b0;
         first_q  <= 1'b1;
         a_done_q <= 1'b0;
         r_done_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         p_vld_q  <= acc_en;
         p_last_q <= acc_en & last;
         if (acc_en) p_cnt_q <= cnt_q + J_WIDTH'(1);
         if (p_vld_q) begin
            first_q <= p_last_q;
            a_cnt_q <= p_cnt_q;
         end
         a_done_q <= p_vld_q & p_last_q;
         r_done_q <= a_done_q;
      end
   end

   // Hold blocks input from the closing beat until the result is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             hold_q <= 1'b0;
      else if (acc_en & last)                 hold_q <= 1'b1;
      else if (beta_tvalid_q & beta_tready)   hold_q <= 1'b0;
   end

   // Output register; loads once per vector so it is stable under stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beta_q        <= '0;
         beta_sat_q    <= '0;
         beta_count_q  <= '0;
         beta_tvalid_q <= 1'b0;
      end else if (r_done_q) begin
         beta_q        <= lane_r;
         beta_sat_q    <= lane_sat;
         beta_count_q  <= a_cnt_q;
         beta_tvalid_q <= 1'b1;
      end else if (beta_tvalid_q & beta_tready) begin
         beta_tvalid_q <= 1'b0;
      end
   end

   // Sticky protocol error flags, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_tlast_q <= 1'b0;
         err_len_q   <= 1'b0;
      end else if (acc_en) begin
         if (vinput_tlast ^ M_row_tlast) err_tlast_q <= 1'b1;
         if ((cnt_q == J_WIDTH'(J-1)) & ~vinput_tlast & ~M_row_tlast) err_len_q <= 1'b1;
      end
   end

   assign beta        = beta_q;
   assign beta_sat    = beta_sat_q;
   assign beta_count  = beta_count_q;
   assign beta_tvalid = beta_tvalid_q;
   assign err_tlast   = err_tlast_q;
   assign err_len     = err_len_q;
endmodule

// File: tb/tb_mac_array_fx.sv
// Testbench for mac_array_fx: table vectors with constant expectations,
// hand sequences for backpressure/errors/reset, and random vectors checked
// against an arithmetic model of sums, rounding and saturation.

module tb_mac_array_fx;
   localparam int A = 2, J = 14, DW = 16, FRAC = 8, OW = 16, JW = $clog2(J) + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DW-1:0]     vinput;
   logic              vinput_tvalid, vinput_tlast;
   logic [A*DW-1:0]   M_row;
   logic              M_row_tvalid, M_row_tlast;
   logic              in_tready;
   logic [A*OW-1:0]   beta;
   logic              beta_tvalid, beta_tready;
   logic [A-1:0]      beta_sat;
   logic [JW-1:0]     beta_count;
   logic              err_tlast, err_len;

   always #5 clk = ~clk;

   mac_array_fx #(.A(A), .J(J), .DW(DW), .FRAC(FRAC), .OW(OW)) dut (
      .clk(clk), .rst_n(rst_n),
      .vinput(vinput), .vinput_tvalid(vinput_tvalid), .vinput_tlast(vinput_tlast),
      .M_row(M_row), .M_row_tvalid(M_row_tvalid), .M_row_tlast(M_row_tlast),
      .in_tready(in_tready),
      .beta(beta), .beta_tvalid(beta_tvalid), .beta_tready(beta_tready),
      .beta_sat(beta_sat), .beta_count(beta_count),
      .err_tlast(err_tlast), .err_len(err_len)
   );

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   longint           m_sum[A];
   int               m_cnt = 0;
   bit               e_len = 0, e_tl = 0;
   logic [OW-1:0]    e_beta[A];
   logic [A-1:0]     e_sat;
   int               e_cnt;

   function automatic void model_reset();
      for (int a = 0; a < A; a++) m_sum[a] = 0;
      m_cnt = 0; e_len = 0; e_tl = 0;
   endfunction

   function automatic void model_beat(input logic [DW-1:0] v, input logic [A*DW-1:0] row,
                                      input bit vt, input bit mt);
      longint r, maxv, minv;
      bit lst;
      maxv = (longint'(1) << (OW-1)) - 1;
      minv = -(longint'(1) << (OW-1));
      for (int a = 0; a < A; a++)
         m_sum[a] += longint'($signed(v)) * longint'($signed(row[a*DW +: DW]));
      m_cnt++;
      lst = vt | mt | (m_cnt == J);
      if (vt != mt) e_tl = 1;
      if (m_cnt == J && !vt && !mt) e_len = 1;
      if (lst) begin
         for (int a = 0; a < A; a++) begin
            r = (m_sum[a] + (longint'(1) << (FRAC-1))) >>> FRAC;
            e_sat[a] = 1'b0;
            if (r > maxv) begin r = maxv; e_sat[a] = 1'b1; end
            if (r < minv) begin r = minv; e_sat[a] = 1'b1; end
            e_beta[a] = r[OW-1:0];
            m_sum[a] = 0;
         end
         e_cnt = m_cnt;
         m_cnt = 0;
      end
   endfunction

   // ---------------- drivers ----------------
   task automatic send_beat(input logic [DW-1:0] v, input logic [A*DW-1:0] row,
                            input bit vt, input bit mt, input int gap);
      int t = 0;
      @(negedge clk);
      vinput = v; M_row = row; vinput_tlast = vt; M_row_tlast = mt;
      vinput_tvalid = 1'b1; M_row_tvalid = 1'b1;
      while (!in_tready && t < 50) begin @(negedge clk); t++; end
      if (!in_tready) begin
         $display("FAIL in_tready_timeout: got 0 expected 1");
         $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
         $fatal(1);
      end
      @(posedge clk);
      model_beat(v, row, vt, mt);
      #1;
      vinput_tvalid = 1'b0; M_row_tvalid = 1'b0;
      vinput_tlast = 1'b0; M_row_tlast = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // Called right after the closing beat's edge; expects valid 3 edges later
   task automatic wait_valid(input string tag);
      int lat = 0;
      while (beta_tvalid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      check({tag, "_latency"}, lat, 3);
   endtask

   task automatic check_model(input string tag);
      for (int a = 0; a < A; a++)
         check($sformatf("%s_beta%0d", tag, a), beta[a*OW +: OW], e_beta[a]);
      check({tag, "_sat"}, beta_sat, e_sat);
      check({tag, "_count"}, beta_count, e_cnt);
      check({tag, "_err_len"}, err_len, e_len);
      check({tag, "_err_tlast"}, err_tlast, e_tl);
   endtask

   // Stall the consumer, checking the result holds, then take it
   task automatic handshake(input string tag, input int stall);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check({tag, "_stall_beta0"}, beta[OW-1:0], e_beta[0]);
         check({tag, "_stall_tready"}, in_tready, 0);
      end
      @(negedge clk);
      beta_tready = 1'b1;
      @(posedge clk);
      #1;
      beta_tready = 1'b0;
      check({tag, "_tvalid_clr"}, beta_tvalid, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int                   n;
      logic [3:0][DW-1:0]   v, m0, m1;
      logic [OW-1:0]        b0, b1;
      logic [1:0]           sat;
      int                   cnt;
      int                   gap;
   } vec_t;

   function automatic vec_t mk(input int n, input logic [63:0] v, input logic [63:0] m0,
                               input logic [63:0] m1, input logic [15:0] b0,
                               input logic [15:0] b1, input logic [1:0] s, input int gap);
      vec_t t;
      t.n = n; t.v = v; t.m0 = m0; t.m1 = m1;
      t.b0 = b0; t.b1 = b1; t.sat = s; t.cnt = n; t.gap = gap;
      return t;
   endfunction

   task automatic send_vec(input vec_t t);
      for (int i = 0; i < t.n; i++)
         send_beat(t.v[i], {t.m1[i], t.m0[i]}, i == t.n-1, i == t.n-1,
                   (i < t.n-1) ? t.gap : 0);
   endtask

   task automatic check_tbl(input vec_t t, input string tag);
      check({tag, "_beta0"}, beta[OW-1:0], t.b0);
      check({tag, "_beta1"}, beta[2*OW-1:OW], t.b1);
      check({tag, "_sat"}, beta_sat, t.sat);
      check({tag, "_count"}, beta_count, t.cnt);
   endtask

   vec_t tbl[7];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0]   rv;
      logic [A*DW-1:0] rrow;
      int              n;
      bit              drop;

      tbl[0] = mk(2, 64'h0000_0000_0200_0100, 64'h0000_0000_0300_0200,
                  64'h0000_0000_0400_0300, 16'h0800, 16'h0B00, 2'b00, 3);
      tbl[1] = mk(2, 64'h0000_0000_7F00_7F00, 64'h0000_0000_7F00_7F00,
                  64'h0000_0000_8100_8100, 16'h7FFF, 16'h8000, 2'b11, 0);
      tbl[2] = mk(1, 64'h1, 64'h0080, 64'h0, 16'h0001, 16'h0000, 2'b00, 0);
      tbl[3] = mk(1, 64'h1, 64'h007F, 64'h0, 16'h0000, 16'h0000, 2'b00, 0);
      tbl[4] = mk(1, 64'hFFFF, 64'h0080, 64'h0081, 16'h0000, 16'hFFFF, 2'b00, 0);
      tbl[5] = mk(2, 64'h0000_0000_0400_0300, 64'h0000_0000_0400_0500,
                  64'h0000_0000_0600_0500, 16'h1F00, 16'h2700, 2'b00, 1);
      tbl[6] = mk(4, 64'h0400_0300_0200_0100, 64'h0100_0100_0100_0100,
                  64'hFF00_FF00_FF00_FF00, 16'h0A00, 16'hF600, 2'b00, 0);

      rst_n = 1'b0;
      vinput = '0; M_row = '0; vinput_tvalid = 1'b0; M_row_tvalid = 1'b0;
      vinput_tlast = 1'b0; M_row_tlast = 1'b0; beta_tready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_beta", beta, 0);
      check("rst_tvalid", beta_tvalid, 0);
      check("rst_sat", beta_sat, 0);
      check("rst_count", beta_count, 0);
      check("rst_in_tready", in_tready, 1);
      check("rst_errs", {err_tlast, err_len}, 0);
      rst_n = 1'b1;

      // Table vectors, stall count varied per entry
      for (int i = 0; i < 7; i++) begin
         send_vec(tbl[i]);
         wait_valid($sformatf("tbl%0d", i));
         check_tbl(tbl[i], $sformatf("tbl%0d", i));
         check_model($sformatf("tbl%0d", i));
         handshake($sformatf("tbl%0d", i), i % 3);
      end

      // Backpressure: next vector offered while result is stalled
      send_beat(16'h0100, {16'h0200, 16'h0100}, 1, 1, 0);
      wait_valid("bp0");
      check_model("bp0");
      @(negedge clk);
      vinput = 16'h0300; M_row = {16'h0500, 16'h0500};
      vinput_tvalid = 1'b1; M_row_tvalid = 1'b1;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         check("bp_in_tready", in_tready, 0);
         check("bp_beta", beta, {16'h0200, 16'h0100});
         check("bp_tvalid", beta_tvalid, 1);
      end
      beta_tready = 1'b1;
      @(posedge clk);
      #1;
      beta_tready = 1'b0; vinput_tvalid = 1'b0; M_row_tvalid = 1'b0;
      check("bp_tvalid_clr", beta_tvalid, 0);
      check("bp_in_tready_back", in_tready, 1);
      send_vec(tbl[5]);
      wait_valid("bp1");
      check_tbl(tbl[5], "bp1");
      handshake("bp1", 0);

      // Length limit: 14 beats, no tlast
      check("len_pre", err_len, 0);
      for (int i = 0; i < J; i++) send_beat(16'h0100, {16'h0100, 16'h0100}, 0, 0, 0);
      wait_valid("len");
      check("len_beta0", beta[OW-1:0], 16'h0E00);
      check("len_count", beta_count, 14);
      check("len_err", err_len, 1);
      check("len_tl", err_tlast, 0);
      handshake("len", 0);

      // tlast disagreement closes the vector and sticks
      send_beat(16'h0100, {16'h0100, 16'h0300}, 1, 0, 0);
      wait_valid("tl");
      check("tl_beta0", beta[OW-1:0], 16'h0300);
      check("tl_count", beta_count, 1);
      check("tl_err", err_tlast, 1);
      handshake("tl", 0);
      send_beat(16'h0100, {16'h0100, 16'h0100}, 1, 1, 0);
      wait_valid("tl2");
      check("tl_sticky", err_tlast, 1);
      handshake("tl2", 0);

      // Random vectors against the model
      for (int r = 0; r < 40; r++) begin
         n = $urandom_range(1, J);
         drop = (n == J) && ($urandom_range(0, 1) == 1);
         for (int i = 0; i < n; i++) begin
            rv = DW'($urandom);
            rrow = (A*DW)'($urandom);
            if ($urandom_range(0, 1) == 1) begin
               rv = {{(DW-10){rv[9]}}, rv[9:0]};
               for (int a = 0; a < A; a++)
                  rrow[a*DW +: DW] = {{(DW-10){rrow[a*DW+9]}}, rrow[a*DW +: 10]};
            end
            send_beat(rv, rrow, (i == n-1) && !drop, (i == n-1) && !drop,
                      (i < n-1) ? $urandom_range(0, 2) : 0);
         end
         wait_valid($sformatf("rnd%0d", r));
         check_model($sformatf("rnd%0d", r));
         handshake($sformatf("rnd%0d", r), $urandom_range(0, 3));
      end

      // Reset mid-vector discards the partial sum
      send_beat(16'h0100, {16'h0100, 16'h0100}, 0, 0, 0);
      send_beat(16'h0100, {16'h0100, 16'h0100}, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mrst_beta", beta, 0);
      check("mrst_tvalid", beta_tvalid, 0);
      check("mrst_sat", beta_sat, 0);
      check("mrst_count", beta_count, 0);
      check("mrst_errs", {err_tlast, err_len}, 0);
      check("mrst_in_tready", in_tready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      send_beat(16'h0100, {16'h0000, 16'h0200}, 1, 1, 0);
      wait_valid("mrst");
      check("mrst_beta0", beta[OW-1:0], 16'h0200);
      check("mrst_count1", beta_count, 1);
      check_model("mrst");
      handshake("mrst", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mac_array_fx.md
Name: mac_array_fx

Overview:
- Parametrised fixed-point successor to the A-lane multiply-accumulate block.
- Each accepted beat multiplies one scalar `vinput` by every lane of `M_row`, and each lane accumulates its product.
- On the vector's last beat, every lane emits one rounded, saturated result. The result is held under valid/ready backpressure.
- Sits between the row-streaming engine and the beta consumer in the solver datapath.

Parameters:
- A, 2: number of lanes (elements per `M_row` beat).
- J, 14: maximum terms per vector. `J_WIDTH = $clog2(J)+1`.
- DW, 16: signed input width (`vinput` and each `M_row` element).
- FRAC, 8: fractional bits of the input format. The result is shifted right by FRAC.
- OW, 16: signed output width per lane.
- Derived `AW = 2*DW + $clog2(J) + 1`: accumulator width, which cannot overflow.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `vinput`, in, DW: signed scalar for the current term.
- `vinput_tvalid`, in, 1: `vinput` valid.
- `vinput_tlast`, in, 1: last term of the vector.
- `M_row`, in, A*DW: lane a is at `[a*DW +: DW]`, signed.
- `M_row_tvalid`, in, 1: `M_row` valid.
- `M_row_tlast`, in, 1: last term of the vector.
- `in_tready`, out, 1: block can accept a beat.
- `beta`, out, A*OW: lane a is at `[a*OW +: OW]`, signed.
- `beta_tvalid`, out, 1: result valid.
- `beta_tready`, in, 1: consumer accepts the result.
- `beta_sat`, out, A: per-lane flag, set when that lane saturated.
- `beta_count`, out, J_WIDTH: number of terms in the emitted result.
- `err_tlast`, out, 1: sticky; the two tlast inputs disagreed on an accepted beat.
- `err_len`, out, 1: sticky; J terms arrived without a tlast.

Behaviour:
- **Reset (async, rst_n=0):**
  - `beta`, `beta_sat`, `beta_count`, `beta_tvalid`, `err_tlast`, `err_len` = 0.
  - `in_tready` = 1.
  - Pipeline valids and the term counter = 0. First-term flag = 1.
  - Reset mid-vector discards all partial accumulation. No result is emitted for it.
- **Beat accept:** `acc_en = vinput_tvalid & M_row_tvalid & in_tready`. Neither stream is consumed alone.
- **Effective last:** `last = (vinput_tlast | M_row_tlast) | (term_cnt == J-1)`.
  - If the two tlast inputs differ on an accepted beat, `err_tlast` is set.
  - If the J-limit forces last and neither tlast is set, `err_len` is set.
  - Both error flags are cleared only by reset.
- **Stage P (edge after accept):**
  - `prod[a] <= vinput * M_row[a]`, full 2*DW signed.
  - `p_valid <= acc_en`, `p_last <= last`.
- **Stage ACC (when `p_valid`):**
  - `acc[a] <= (first ? 0 : acc[a]) + sext(prod[a])`.
  - `first <= p_last`, `a_done <= p_last`.
  - The term counter increments on each `acc_en` and resets to 0 on an accepted last beat. It is latched into `beta_count` on `a_done`.
- **Stage OUT (on `a_done`):**
  - Round: `r = (acc + (FRAC>0 ? 1<<(FRAC-1) : 0)) >>> FRAC` (round-half-up, arithmetic shift).
  - Saturate `r` to [-2^(OW-1), 2^(OW-1)-1]. `beta_sat[a]` = 1 if lane a was clipped.
  - Set `beta_tvalid <= 1`.
- **Latency:** last beat accepted at edge k → `beta_tvalid` is high after edge k+3.
- **Hold register:**
  - `hold` is set on the edge that accepts the last beat. It clears on the `beta_tvalid & beta_tready` edge, which also clears `beta_tvalid`.
  - `in_tready = ~hold`, so the next vector is accepted at the earliest on the cycle after the handshake.
  - Beats between vectors are therefore back-pressured, never dropped.
- **Output stability:** `beta`, `beta_sat` and `beta_count` stay stable while `beta_tvalid & ~beta_tready`.
- **Simultaneous events:**
  - The handshake edge and a new beat cannot coincide, because `in_tready` is 0 while `hold` is set.
  - Gaps (valid low) inside a vector are allowed and leave the accumulators unchanged.
- **One-term vector:** `tlast` on the first beat is legal. `beta` is then that single rounded product.

Test Plan:
1. **Basic (Q8.8):**
   - Stimulus: beat 1 `vinput`=0x0100, `M_row`={0x0300,0x0200}; gap of 3 cycles; beat 2 `vinput`=0x0200, `M_row`={0x0400,0x0300}, both tlast set.
   - Response: beta[0]=0x0800, beta[1]=0x0B00, `beta_count`=2, `beta_sat`=0. `beta_tvalid` goes high exactly 3 edges after beat 2.
2. **Saturation:**
   - Stimulus: lane0 = 2 × (0x7F00 × 0x7F00); lane1 = 2 × (0x7F00 × 0x8100).
   - Response: beta[0]=0x7FFF, beta[1]=0x8000, `beta_sat`=2'b11.
3. **Rounding:**
   - Stimulus: 0x0001 × 0x0080 on lane0, one-term vector.
   - Response: beta[0]=0x0001. A one-term 0x0001 × 0x007F gives 0x0000.
4. **Backpressure:**
   - Stimulus: hold `beta_tready`=0 for 5 cycles while the next vector's beats are offered.
   - Response: `in_tready`=0, `beta` stable, no beat consumed. After the handshake, the next vector yields the correct independent result (3.0,4.0 / 4.0,5.0 case → 0x1F00 and 0x2700).
5. **Length / tlast errors:**
   - Stimulus A: 14 beats of 0x0100 × 0x0100 with no tlast. Response: beta=0x0E00, `beta_count`=14, `err_len`=1.
   - Stimulus B: a beat with `vinput_tlast`=1 and `M_row_tlast`=0. Response: the vector closes and `err_tlast`=1, remaining set until reset.
6. **Reset mid-vector:**
   - Stimulus: assert `rst_n` low after 2 of 4 beats, then run a fresh 1-term vector of 0x0100 × 0x0200.
   - Response: all outputs are 0 during reset; the fresh vector yields 0x0200.
